pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high, named clk and rst.
REQ-002 Parameter DATA_W, default 32, SHALL set the operand width.
REQ-003 Parameter NUM_OPS, default 3, SHALL set the operand count: val1, val2 and store value.
REQ-004 Parameter CMD_W, default 4, SHALL set the execute-command width.
REQ-005 Parameter REG_W, default 5, SHALL set the register-address width.
REQ-006 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept
- in_ops  in  NUM_OPS*DATA_W  operands; op0 in the LSBs
- in_cmd  in  CMD_W  execute command
- in_dest, in_src1, in_src2  in  REG_W each  destination and source register addresses
- in_mem_r, in_mem_w, in_wb, in_br  in  1 each  control flags
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream accepts
- out_ops, out_cmd, out_dest, out_src1, out_src2  out  same widths as inputs  registered payload
- out_mem_r, out_mem_w, out_wb, out_br  out  1 each  registered flags, valid-gated
- occupancy  out  2  held entries, 0..2

Function
REQ-007 Storage SHALL be a main register (drives outputs) plus one skid register, each with a valid bit.
REQ-008 Accept SHALL occur when in_valid and in_ready are both 1; transfer SHALL occur when out_valid and out_ready are both 1.
REQ-009 in_ready SHALL be the registered inverse of skid valid, with no combinational path from out_ready.
REQ-010 With the main register empty, or transferring, and the skid register empty, an accepted entry SHALL load main: latency 1 cycle, throughput 1 entry per cycle.
REQ-011 Main full, no transfer, accept: the entry SHALL load skid, and in_ready SHALL be 0 from the next cycle.
REQ-012 Skid full and transfer: skid SHALL move to main, skid SHALL become empty, and in_ready SHALL be 1 on the next cycle.
REQ-013 Entries SHALL leave in acceptance order, with none lost or duplicated.
REQ-014 Flag outputs SHALL equal the stored flag AND out_valid, so that a bubble never writes memory, the register file or the branch unit.
REQ-015 When invalid, payload outputs SHALL hold their last value.
REQ-016 flush SHALL clear both valid bits at the next edge and SHALL have priority over a simultaneous accept or transfer (the input is dropped).
REQ-017 After flush, in_ready SHALL be 1 and occupancy SHALL be 0.
REQ-018 occupancy SHALL equal main valid plus skid valid.

Reset
REQ-019 While rst is high, both valid bits SHALL be 0, all payload and flag registers SHALL be 0, in_ready SHALL be 1 and occupancy SHALL be 0, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard held entries; the first accept after deassertion SHALL load main.

Structure
REQ-021 Shared package pipeline_pkg SHALL hold the DATA_W, CMD_W and REG_W defaults and the ID/EX control-bundle typedef (cmd, mem_r, mem_w, wb, br).
REQ-022 Sub-module pipe_slot, a valid-plus-payload register with load and clear, SHALL be instantiated twice (main and skid).

Verification
REQ-023 Streaming: in_valid=1 and out_ready=1 for 8 cycles, ops 0x1..0x8 -> outputs 0x1..0x8, one per cycle, each 1 cycle after its accept.
REQ-024 Backpressure: out_ready=0 with entries A=0x11 and B=0x22 sent -> occupancy=2, in_ready=0; release out_ready -> A then B in consecutive cycles.
REQ-025 Flush while occupancy=2 and in_valid=1 (ops 0x33) -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x33 never appears.
REQ-026 Bubble gating: entry with in_wb=1 and in_mem_w=1 consumed, then no input -> out_wb=0 and out_mem_w=0 while out_ops hold the last value.
REQ-027 Asynchronous reset pulse between clock edges with occupancy=2 -> all outputs 0 immediately and in_ready=1; the next entry 0x44 emerges with latency 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared ID/EX pipeline types: default widths, control-bundle typedef, flag gating helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int NUM_OPS_DEF = 3;
  localparam int CMD_W_DEF   = 4;
  localparam int REG_W_DEF   = 5;

  // Side-effect flags carried alongside each instruction. Order is fixed
  // because the stage flattens it into its payload vector.
  typedef struct packed {
    logic mem_r;
    logic mem_w;
    logic wb;
    logic br;
  } flags_t;

  // ID/EX control bundle at the default command width.
  typedef struct packed {
    logic [CMD_W_DEF-1:0] cmd;
    flags_t               flags;
  } ctrl_t;

  // A bubble must never look like a memory write, register write or branch.
  function automatic flags_t gate_flags(flags_t f, logic v);
    return v ? f : '0;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Valid-plus-payload register with load and clear; clear only drops the valid bit.
// Latency: 1 cycle from load to valid/q.
// Backpressure: none; the owner decides when to load or clear.
// Ports: clk, rst (async active-high), load, clear, d[W] -> valid, q[W].
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Payload is left untouched on clear so the stage outputs hold their
  // last value while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// ID/EX pipeline register with a one-entry skid buffer so in_ready is fully registered.
// Latency: 1 cycle in to out; 1 entry/cycle throughput while out_ready stays high.
// Backpressure: in_ready = ~skid valid; out_ready never reaches in_ready combinationally.
// Ports: clk, rst, flush; in_valid/in_ready + in_ops/cmd/dest/src1/src2/flags;
//        out_valid/out_ready + out_ops/cmd/dest/src1/src2/flags (flags valid-gated); occupancy.
module pipe_stage_skid
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF,
  parameter int CMD_W   = CMD_W_DEF,
  parameter int REG_W   = REG_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [CMD_W-1:0]          in_cmd,
  input  logic [REG_W-1:0]          in_dest,
  input  logic [REG_W-1:0]          in_src1,
  input  logic [REG_W-1:0]          in_src2,
  input  logic                      in_mem_r,
  input  logic                      in_mem_w,
  input  logic                      in_wb,
  input  logic                      in_br,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [CMD_W-1:0]          out_cmd,
  output logic [REG_W-1:0]          out_dest,
  output logic [REG_W-1:0]          out_src1,
  output logic [REG_W-1:0]          out_src2,
  output logic                      out_mem_r,
  output logic                      out_mem_w,
  output logic                      out_wb,
  output logic                      out_br,
  output logic [1:0]                occupancy
);

  typedef struct packed {
    logic [NUM_OPS*DATA_W-1:0] ops;
    logic [CMD_W-1:0]          cmd;
    logic [REG_W-1:0]          dest;
    logic [REG_W-1:0]          src1;
    logic [REG_W-1:0]          src2;
    flags_t                    flags;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t in_pl;
  payload_t m_q;
  payload_t s_q;
  payload_t m_d;
  logic     m_v, s_v;
  logic     m_load, m_clear, s_load, s_clear;
  logic     accept, xfer;
  flags_t   out_flags;

  assign in_pl = {in_ops, in_cmd, in_dest, in_src1, in_src2,
                  in_mem_r, in_mem_w, in_wb, in_br};

  assign in_ready = ~s_v;
  assign accept   = in_valid & in_ready;
  assign xfer     = m_v & out_ready;

  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = in_pl;
    if (flush) begin
      // Kill both entries; any simultaneous accept is dropped.
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (s_v) begin
      // in_ready is low here, so nothing can be accepted this cycle.
      if (xfer) begin
        m_load  = 1'b1;
        m_d     = s_q;
        s_clear = 1'b1;
      end
    end else if (!m_v || xfer) begin
      if (accept) begin
        m_load = 1'b1;
      end else if (xfer) begin
        m_clear = 1'b1;
      end
    end else if (accept) begin
      // Main is stalled: park the entry that arrived under the registered ready.
      s_load = 1'b1;
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_v),
    .q     (m_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (s_load),
    .clear (s_clear),
    .d     (in_pl),
    .valid (s_v),
    .q     (s_q)
  );

  assign out_valid = m_v;
  assign out_ops   = m_q.ops;
  assign out_cmd   = m_q.cmd;
  assign out_dest  = m_q.dest;
  assign out_src1  = m_q.src1;
  assign out_src2  = m_q.src2;

  assign out_flags = gate_flags(m_q.flags, m_v);
  assign out_mem_r = out_flags.mem_r;
  assign out_mem_w = out_flags.mem_w;
  assign out_wb    = out_flags.wb;
  assign out_br    = out_flags.br;

  assign occupancy = {1'b0, m_v} + {1'b0, s_v};

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_ops;
  logic [3:0]  in_cmd;
  logic [4:0]  in_dest, in_src1, in_src2;
  logic        in_mem_r, in_mem_w, in_wb, in_br;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_ops;
  logic [3:0]  out_cmd;
  logic [4:0]  out_dest, out_src1, out_src2;
  logic        out_mem_r, out_mem_w, out_wb, out_br;
  logic [1:0]  occupancy;

  int n_chk;
  int n_fail;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .in_cmd    (in_cmd),
    .in_dest   (in_dest),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_mem_r  (in_mem_r),
    .in_mem_w  (in_mem_w),
    .in_wb     (in_wb),
    .in_br     (in_br),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ops   (out_ops),
    .out_cmd   (out_cmd),
    .out_dest  (out_dest),
    .out_src1  (out_src1),
    .out_src2  (out_src2),
    .out_mem_r (out_mem_r),
    .out_mem_w (out_mem_w),
    .out_wb    (out_wb),
    .out_br    (out_br),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk_ops(input logic [31:0] v);
    return {v + 32'h200, v + 32'h100, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] val, input logic rdy);
    in_valid  = v;
    in_ops    = mk_ops(val);
    in_cmd    = val[3:0];
    in_dest   = val[4:0];
    in_src1   = ~val[4:0];
    in_src2   = val[4:0] ^ 5'h0a;
    out_ready = rdy;
  endtask

  initial begin
    logic [31:0] v;
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    in_mem_r = 1'b0;
    in_mem_w = 1'b0;
    in_wb    = 1'b0;
    in_br    = 1'b0;
    drv(1'b0, 32'h0, 1'b0);

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_ops", out_ops, 96'h0);
    tick();
    rst = 1'b0;

    // Streaming: one entry per cycle, each visible one cycle after accept.
    for (int i = 1; i <= 8; i++) begin
      v = i;
      drv(1'b1, v, 1'b1);
      tick();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_ops", out_ops, mk_ops(v));
      chk("stream_cmd", out_cmd, v[3:0]);
      chk("stream_occ", occupancy, 2'd1);
      chk("stream_in_ready", in_ready, 1'b1);
    end
    drv(1'b0, 32'h0, 1'b1);
    tick();
    chk("stream_drain_valid", out_valid, 1'b0);
    chk("stream_drain_occ", occupancy, 2'd0);
    chk("stream_hold_ops", out_ops, mk_ops(32'h8));

    // Backpressure: A in main, B in skid, C refused while full.
    drv(1'b1, 32'h11, 1'b0);
    tick();
    chk("bp_a_occ", occupancy, 2'd1);
    drv(1'b1, 32'h22, 1'b0);
    tick();
    chk("bp_full_occ", occupancy, 2'd2);
    chk("bp_full_in_ready", in_ready, 1'b0);
    chk("bp_full_ops", out_ops, mk_ops(32'h11));
    drv(1'b1, 32'h23, 1'b0);
    tick();
    chk("bp_refuse_occ", occupancy, 2'd2);
    chk("bp_refuse_ops", out_ops, mk_ops(32'h11));
    drv(1'b0, 32'h0, 1'b1);
    #1;
    chk("bp_rel_a_valid", out_valid, 1'b1);
    chk("bp_rel_a_ops", out_ops, mk_ops(32'h11));
    tick();
    chk("bp_rel_b_valid", out_valid, 1'b1);
    chk("bp_rel_b_ops", out_ops, mk_ops(32'h22));
    chk("bp_rel_b_dest", out_dest, 5'h02);
    chk("bp_rel_b_src1", out_src1, 5'h1d);
    chk("bp_rel_b_src2", out_src2, 5'h08);
    chk("bp_rel_occ", occupancy, 2'd1);
    chk("bp_rel_in_ready", in_ready, 1'b1);
    tick();
    chk("bp_empty_valid", out_valid, 1'b0);
    chk("bp_empty_occ", occupancy, 2'd0);

    // Flush while full, with an input offered at the same edge.
    drv(1'b1, 32'h55, 1'b0);
    tick();
    drv(1'b1, 32'h66, 1'b0);
    tick();
    chk("fl_pre_occ", occupancy, 2'd2);
    drv(1'b1, 32'h33, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_occ", occupancy, 2'd0);
    chk("fl_in_ready", in_ready, 1'b1);
    chk("fl_hold_ops", out_ops, mk_ops(32'h55));
    drv(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fl_after_valid", out_valid, 1'b0);
      chk("fl_after_ops", out_ops, mk_ops(32'h55));
    end

    // Flush beats a simultaneous accept when main alone is occupied.
    drv(1'b1, 32'h12, 1'b0);
    tick();
    chk("fl1_pre_occ", occupancy, 2'd1);
    drv(1'b1, 32'h34, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drv(1'b0, 32'h0, 1'b1);
    chk("fl1_occ", occupancy, 2'd0);
    chk("fl1_valid", out_valid, 1'b0);
    chk("fl1_ops", out_ops, mk_ops(32'h12));

    // Bubble gating of side-effect flags.
    drv(1'b1, 32'h77, 1'b1);
    in_wb    = 1'b1;
    in_mem_w = 1'b1;
    in_br    = 1'b1;
    tick();
    chk("bub_live_wb", out_wb, 1'b1);
    chk("bub_live_mem_w", out_mem_w, 1'b1);
    chk("bub_live_br", out_br, 1'b1);
    chk("bub_live_mem_r", out_mem_r, 1'b0);
    drv(1'b0, 32'h0, 1'b1);
    in_wb    = 1'b0;
    in_mem_w = 1'b0;
    in_br    = 1'b0;
    tick();
    chk("bub_valid", out_valid, 1'b0);
    chk("bub_wb", out_wb, 1'b0);
    chk("bub_mem_w", out_mem_w, 1'b0);
    chk("bub_br", out_br, 1'b0);
    chk("bub_hold_ops", out_ops, mk_ops(32'h77));

    // Asynchronous reset pulse between edges while full.
    drv(1'b1, 32'h88, 1'b0);
    in_wb = 1'b1;
    tick();
    drv(1'b1, 32'h99, 1'b0);
    tick();
    in_wb = 1'b0;
    drv(1'b0, 32'h0, 1'b0);
    chk("ar_pre_occ", occupancy, 2'd2);
    chk("ar_pre_wb", out_wb, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_occ", occupancy, 2'd0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_ops", out_ops, 96'h0);
    chk("ar_cmd", out_cmd, 4'h0);
    chk("ar_wb", out_wb, 1'b0);
    #1;
    rst = 1'b0;
    drv(1'b1, 32'h44, 1'b1);
    tick();
    chk("ar_next_valid", out_valid, 1'b1);
    chk("ar_next_ops", out_ops, mk_ops(32'h44));
    chk("ar_next_occ", occupancy, 2'd1);
    drv(1'b0, 32'h0, 1'b1);
    tick();
    chk("ar_end_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
